flash_op_arbiter: RTL
=====================

// Module: flash_op_arbiter
// PURPOSE
//   Shares the single SPI-flash controller user interface between two requesters (m0, m1).
//   Shared items: op command, write stream and read stream.
//   Grants one requester per operation and holds the grant until the controller signals completion.
//   Routes the granted requester's command and write stream to the controller, and returns read data to it alone.
//   Sits between the user data generators and the flash controller.
// PARAMETERS
//   P_FIXED_PRIO  0  0: round-robin between m0/m1; 1: m0 always wins contention
//   P_GAP_CYCLES  2  idle cycles inserted after each completed operation before the next grant (0 = none)
// PORTS
//   i_clk                 in   1   system clock
//   i_rst                 in   1   asynchronous reset, active-high
//   i_m{0,1}_op_type      in   2   per-requester op type (0 erase, 1 write, 2 read)
//   i_m{0,1}_op_addr      in   24  per-requester flash byte address
//   i_m{0,1}_op_num       in   9   per-requester byte count
//   i_m{0,1}_op_valid     in   1   command request; held high until o_m*_op_ready
//   o_m{0,1}_op_ready     out  1   command accepted (handshake = valid & ready)
//   i_m{0,1}_write_data/sop/eop/valid  in  8/1/1/1  per-requester write stream
//   o_m{0,1}_read_data/sop/eop/valid   out 8/1/1/1  per-requester read stream
//   o_user_op_type/addr/num/valid      out 2/24/9/1 command to controller
//   i_user_op_ready       in   1   controller idle; drops after accept, rises again when the op is done
//   o_user_write_data/sop/eop/valid    out 8/1/1/1  write stream to controller
//   i_user_read_data/sop/eop/valid     in  8/1/1/1  read stream from controller
//   o_grant               out  2   one-hot current grant (00 = none)
//   o_busy                out  1   high in ISSUE, BUSY and GAP
// BEHAVIOUR
//   Reset: FSM=IDLE, o_grant=00, last-grant pointer=m1, ready-history reg=1, counters=0.
//     All outputs are 0 during and after reset.
//     Asserting reset mid-operation aborts the grant; requesters must re-issue.
//   FSM states: IDLE -> ISSUE -> BUSY -> GAP -> IDLE.
//   IDLE:
//     If any i_m*_op_valid is high, register the grant and go to ISSUE on the next edge.
//     Contention: round-robin picks the requester not in the last-grant pointer; fixed mode picks m0.
//   ISSUE:
//     o_user_op_* = granted requester's fields (combinational mux, zero latency).
//     o_mX_op_ready = i_user_op_ready for the granted requester; the other requester's ready = 0.
//     Controller handshake (o_user_op_valid & i_user_op_ready) -> go to BUSY.
//     If the granted valid drops before handshake -> go to IDLE; pointer unchanged.
//   BUSY:
//     o_user_op_valid = 0.
//     Leave on the rising edge of i_user_op_ready (prev reg = 0, current = 1).
//     On leaving, set pointer = granted and go to GAP (or IDLE if P_GAP_CYCLES = 0).
//   GAP: count P_GAP_CYCLES cycles, then go to IDLE and clear o_grant.
//   Write stream:
//     In ISSUE/BUSY, o_user_write_* = granted requester's i_m*_write_*; otherwise 0.
//     The non-granted requester's write inputs are ignored.
//   Read stream:
//     In BUSY, i_user_read_* is routed to the granted requester's o_m*_read_*.
//     The non-granted requester's outputs are 0.
//     Read beats arriving outside BUSY are dropped.
//   No buffering: datapath latency is 0 cycles; arbitration adds 1 cycle (IDLE -> ISSUE).
//   A new request during BUSY/GAP waits; it is evaluated in the next IDLE.
// TESTING
//   1. m0 alone issues write, addr 0x000100, num 2:
//      -> ISSUE one cycle later with o_user_op_type=1; o_m0_op_ready pulses on handshake;
//      -> both write bytes are forwarded unchanged;
//      -> after ready rises, 2 GAP cycles then IDLE.
//   2. After reset, m0 and m1 request in the same cycle (round-robin):
//      -> grant order is m0, then m1;
//      -> a repeated simultaneous request is then granted to m0.
//   3. P_FIXED_PRIO=1, m0 re-requests immediately each time while m1 holds valid:
//      -> m1 never granted; m1 ready stays 0.
//   4. m1 reads 2 bytes:
//      -> o_m1_read_valid pulses twice with controller data and sop/eop;
//      -> o_m0_read_valid stays 0.
//   5. m1 drives write_valid=1, data 0xAA while m0's write is granted:
//      -> o_user_write_data/valid follow m0 only.
//   6. Assert i_rst in BUSY:
//      -> o_grant=00, o_busy=0 and all outputs 0 immediately;
//      -> after release, a pending m1 request is granted within 2 cycles.

Source files
------------

// File: rtl/flash_op_arbiter.sv
// Two-requester arbiter in front of one SPI-flash controller user interface.
// One operation is granted at a time; command, write and read paths are zero-latency muxes.
module flash_op_arbiter #(
    parameter int P_FIXED_PRIO = 0,
    parameter int P_GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_m0_op_type,
    input  logic [23:0] i_m0_op_addr,
    input  logic [8:0]  i_m0_op_num,
    input  logic        i_m0_op_valid,
    output logic        o_m0_op_ready,
    input  logic [7:0]  i_m0_write_data,
    input  logic        i_m0_write_sop,
    input  logic        i_m0_write_eop,
    input  logic        i_m0_write_valid,
    output logic [7:0]  o_m0_read_data,
    output logic        o_m0_read_sop,
    output logic        o_m0_read_eop,
    output logic        o_m0_read_valid,
    input  logic [1:0]  i_m1_op_type,
    input  logic [23:0] i_m1_op_addr,
    input  logic [8:0]  i_m1_op_num,
    input  logic        i_m1_op_valid,
    output logic        o_m1_op_ready,
    input  logic [7:0]  i_m1_write_data,
    input  logic        i_m1_write_sop,
    input  logic        i_m1_write_eop,
    input  logic        i_m1_write_valid,
    output logic [7:0]  o_m1_read_data,
    output logic        o_m1_read_sop,
    output logic        o_m1_read_eop,
    output logic        o_m1_read_valid,
    output logic [1:0]  o_user_op_type,
    output logic [23:0] o_user_op_addr,
    output logic [8:0]  o_user_op_num,
    output logic        o_user_op_valid,
    input  logic        i_user_op_ready,
    output logic [7:0]  o_user_write_data,
    output logic        o_user_write_sop,
    output logic        o_user_write_eop,
    output logic        o_user_write_valid,
    input  logic [7:0]  i_user_read_data,
    input  logic        i_user_read_sop,
    input  logic        i_user_read_eop,
    input  logic        i_user_read_valid,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic [1:0]  o_state
);

    localparam int GAP_LAST = (P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0;
    localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST_V = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      grant, grant_nxt;
    logic            last_m1, last_m1_nxt;
    logic            ready_prev;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;

    logic            both_req;
    logic            pick_m1;
    logic            sel_m1;
    logic [1:0]      sel_type;
    logic [23:0]     sel_addr;
    logic [8:0]      sel_num;
    logic            sel_valid;
    logic            done_edge;

    // Valid/ready: a command transfers on the cycle where valid and ready are
    // both high; a requester holds valid and its fields stable until then.
    assign both_req  = i_m0_op_valid & i_m1_op_valid;
    assign pick_m1   = both_req ? ((P_FIXED_PRIO != 0) ? 1'b0 : ~last_m1) : i_m1_op_valid;

    assign sel_m1    = grant[1];
    assign sel_type  = sel_m1 ? i_m1_op_type  : i_m0_op_type;
    assign sel_addr  = sel_m1 ? i_m1_op_addr  : i_m0_op_addr;
    assign sel_num   = sel_m1 ? i_m1_op_num   : i_m0_op_num;
    assign sel_valid = sel_m1 ? i_m1_op_valid : i_m0_op_valid;

    // Controller completion is the low-to-high transition of its ready.
    assign done_edge = ~ready_prev & i_user_op_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_m1    <= 1'b1;
            ready_prev <= 1'b1;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_m1    <= last_m1_nxt;
            ready_prev <= i_user_op_ready;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_m1_nxt = last_m1;
        gap_cnt_nxt = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (i_m0_op_valid | i_m1_op_valid) begin
                    grant_nxt = pick_m1 ? 2'b10 : 2'b01;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!sel_valid) begin
                    grant_nxt = 2'b00;
                    state_nxt = ST_IDLE;
                end else if (i_user_op_ready) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_edge) begin
                    last_m1_nxt = grant[1];
                    if (P_GAP_CYCLES == 0) begin
                        grant_nxt = 2'b00;
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_cnt_nxt = '0;
                        state_nxt   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST_V) begin
                    gap_cnt_nxt = '0;
                    grant_nxt   = 2'b00;
                    state_nxt   = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_user_op_type     = 2'b00;
        o_user_op_addr     = 24'h000000;
        o_user_op_num      = 9'h000;
        o_user_op_valid    = 1'b0;
        o_m0_op_ready      = 1'b0;
        o_m1_op_ready      = 1'b0;
        o_user_write_data  = 8'h00;
        o_user_write_sop   = 1'b0;
        o_user_write_eop   = 1'b0;
        o_user_write_valid = 1'b0;
        o_m0_read_data     = 8'h00;
        o_m0_read_sop      = 1'b0;
        o_m0_read_eop      = 1'b0;
        o_m0_read_valid    = 1'b0;
        o_m1_read_data     = 8'h00;
        o_m1_read_sop      = 1'b0;
        o_m1_read_eop      = 1'b0;
        o_m1_read_valid    = 1'b0;

        if (state == ST_ISSUE) begin
            o_user_op_type  = sel_type;
            o_user_op_addr  = sel_addr;
            o_user_op_num   = sel_num;
            o_user_op_valid = sel_valid;
            o_m0_op_ready   = grant[0] & i_user_op_ready;
            o_m1_op_ready   = grant[1] & i_user_op_ready;
        end

        if (state == ST_ISSUE || state == ST_BUSY) begin
            o_user_write_data  = sel_m1 ? i_m1_write_data  : i_m0_write_data;
            o_user_write_sop   = sel_m1 ? i_m1_write_sop   : i_m0_write_sop;
            o_user_write_eop   = sel_m1 ? i_m1_write_eop   : i_m0_write_eop;
            o_user_write_valid = sel_m1 ? i_m1_write_valid : i_m0_write_valid;
        end

        // Read beats only reach a requester while its operation is in flight.
        if (state == ST_BUSY) begin
            if (grant[0]) begin
                o_m0_read_data  = i_user_read_data;
                o_m0_read_sop   = i_user_read_sop;
                o_m0_read_eop   = i_user_read_eop;
                o_m0_read_valid = i_user_read_valid;
            end
            if (grant[1]) begin
                o_m1_read_data  = i_user_read_data;
                o_m1_read_sop   = i_user_read_sop;
                o_m1_read_eop   = i_user_read_eop;
                o_m1_read_valid = i_user_read_valid;
            end
        end
    end

    assign o_grant = grant;
    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

endmodule
